// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: divides clk down to MDC and serialises one read or
// write frame per accepted command, returning read data and a turnaround error flag.
module mdio_master #(
    parameter int MDC_DIV = 10,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_done,
    output logic [15:0] rd_data,
    output logic        rd_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);
    localparam int CNT_W = $clog2(2 * MDC_DIV);
    localparam logic [CNT_W-1:0] RISE_AT  = CNT_W'(MDC_DIV - 1);
    localparam logic [CNT_W-1:0] END_AT   = CNT_W'(2 * MDC_DIV - 1);
    localparam logic [5:0]       PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [5:0]       bit_cnt, bit_nxt;
    logic [CNT_W-1:0] ph_cnt, ph_nxt;
    logic             mdc_nxt, out_nxt, oe_nxt;
    logic [15:0]      rd_data_nxt;
    logic             rd_err_nxt;
    logic [31:0]      frame_sr, frame_nxt;
    logic             wr_q, wr_nxt;
    logic [15:0]      rd_sr, rd_sr_nxt;
    logic             ta_err, ta_err_nxt;
    logic             active, rise, bit_end;

    assign active    = (state == S_PRE) || (state == S_HDR) || (state == S_TA) || (state == S_DATA);
    assign rise      = active && (ph_cnt == RISE_AT);
    assign bit_end   = active && (ph_cnt == END_AT);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign cmd_done  = (state == S_DONE);

    always_comb begin
        state_nxt   = state;
        bit_nxt     = bit_cnt;
        ph_nxt      = '0;
        mdc_nxt     = 1'b0;
        out_nxt     = mdio_out;
        oe_nxt      = mdio_oe;
        frame_nxt   = frame_sr;
        wr_nxt      = wr_q;
        rd_sr_nxt   = rd_sr;
        ta_err_nxt  = ta_err;
        rd_data_nxt = rd_data;
        rd_err_nxt  = rd_err;

        if (active) begin
            ph_nxt  = bit_end ? '0 : ph_cnt + CNT_W'(1);
            mdc_nxt = rise | (mdc & ~bit_end);
        end
        if (rise && (state == S_TA) && (bit_cnt == 6'd0))
            ta_err_nxt = mdio_in;
        if (rise && (state == S_DATA))
            rd_sr_nxt = {rd_sr[14:0], mdio_in};

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_nxt    = cmd_write;
                    frame_nxt = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                                 2'b10, (cmd_write ? cmd_wdata : 16'hFFFF)};
                    if (PRE_LEN > 0) begin
                        state_nxt = S_PRE;
                        bit_nxt   = PRE_LAST;
                    end else begin
                        state_nxt = S_HDR;
                        bit_nxt   = 6'd13;
                    end
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                if (bit_end) begin
                    // Preamble bits come from the constant '1', everything after from frame_sr
                    if (state != S_PRE)
                        frame_nxt = {frame_sr[30:0], 1'b0};
                    if (bit_cnt != 6'd0) begin
                        bit_nxt = bit_cnt - 6'd1;
                    end else begin
                        case (state)
                            S_PRE:   begin state_nxt = S_HDR;  bit_nxt = 6'd13; end
                            S_HDR:   begin state_nxt = S_TA;   bit_nxt = 6'd1;  end
                            S_TA:    begin state_nxt = S_DATA; bit_nxt = 6'd15; end
                            default: begin
                                state_nxt = S_DONE;
                                if (!wr_q)
                                    rd_data_nxt = rd_sr;
                                rd_err_nxt = !wr_q && ta_err;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Pin drive only changes at bit boundaries, giving MDC_DIV clks of setup/hold
        if (((state == S_IDLE) && cmd_valid) || bit_end) begin
            case (state_nxt)
                S_PRE:        begin out_nxt = 1'b1;          oe_nxt = 1'b1;   end
                S_HDR:        begin out_nxt = frame_nxt[31]; oe_nxt = 1'b1;   end
                S_TA, S_DATA: begin out_nxt = frame_nxt[31]; oe_nxt = wr_nxt; end
                default:      begin out_nxt = 1'b1;          oe_nxt = 1'b0;   end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            ph_cnt   <= '0;
            mdc      <= 1'b0;
            mdio_out <= 1'b1;
            mdio_oe  <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            ph_cnt   <= ph_nxt;
            mdc      <= mdc_nxt;
            mdio_out <= out_nxt;
            mdio_oe  <= oe_nxt;
            rd_data  <= rd_data_nxt;
            rd_err   <= rd_err_nxt;
        end
    end

    // Frame/shift data is fully reloaded or refilled each frame, so it carries no reset
    always_ff @(posedge clk) begin
        frame_sr <= frame_nxt;
        wr_q     <= wr_nxt;
        rd_sr    <= rd_sr_nxt;
        ta_err   <= ta_err_nxt;
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: a Clause-22 PHY model on a pulled-up bus (MDC_DIV=4,
// PRE_LEN=32) plus a preamble-suppressed instance (MDC_DIV=2, PRE_LEN=0) for back-to-back writes.
module tb_mdio_master;
    localparam logic [4:0] PHY_AD = 5'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rst_a, cv_a, cw_a, ready_a, done_a, rde_a, busy_a, mdc_a, out_a, oe_a, mdio_a;
    logic [4:0]  cpa_a, cra_a;
    logic [15:0] cwd_a, rdd_a;
    logic        rst_b, cv_b, cw_b, ready_b, done_b, rde_b, busy_b, mdc_b, out_b, oe_b, mdio_b;
    logic [4:0]  cpa_b, cra_b;
    logic [15:0] cwd_b, rdd_b;

    logic        phy_oe, phy_out, phy_clr;
    assign mdio_a = oe_a ? out_a : (phy_oe ? phy_out : 1'b1);
    assign mdio_b = oe_b ? out_b : 1'b1;

    mdio_master #(.MDC_DIV(4), .PRE_LEN(32)) dut_a (
        .clk(clk), .reset(rst_a), .cmd_valid(cv_a), .cmd_ready(ready_a), .cmd_write(cw_a),
        .cmd_phy_addr(cpa_a), .cmd_reg_addr(cra_a), .cmd_wdata(cwd_a), .cmd_done(done_a),
        .rd_data(rdd_a), .rd_err(rde_a), .busy(busy_a), .mdc(mdc_a), .mdio_out(out_a),
        .mdio_oe(oe_a), .mdio_in(mdio_a)
    );

    mdio_master #(.MDC_DIV(2), .PRE_LEN(0)) dut_b (
        .clk(clk), .reset(rst_b), .cmd_valid(cv_b), .cmd_ready(ready_b), .cmd_write(cw_b),
        .cmd_phy_addr(cpa_b), .cmd_reg_addr(cra_b), .cmd_wdata(cwd_b), .cmd_done(done_b),
        .rd_data(rdd_b), .rd_err(rde_b), .busy(busy_b), .mdc(mdc_b), .mdio_out(out_b),
        .mdio_oe(oe_b), .mdio_in(mdio_b)
    );

    // Bus bit streams as seen at each MDC rising edge
    logic [63:0] stream_a;
    logic [31:0] stream_b;
    int          scnt_a, scnt_b;
    always @(posedge mdc_a) begin stream_a = {stream_a[62:0], mdio_a}; scnt_a++; end
    always @(posedge mdc_b) begin stream_b = {stream_b[30:0], mdio_b}; scnt_b++; end

    // PHY model: responds at PHY_AD, updates its drive right after each MDC rising edge
    logic [15:0] phy_regs [32];
    bit          regs_ok;
    int          ph_st, ph_ones, ph_n;
    logic        ph_b;
    logic [11:0] ph_hdr;
    logic [17:0] ph_wr;
    logic [15:0] ph_rdv;
    always @(posedge mdc_a or posedge phy_clr) begin
        if (phy_clr) begin
            if (!regs_ok) begin
                for (int i = 0; i < 32; i++) phy_regs[i] = 16'hC000 | 16'(i);
                regs_ok = 1'b1;
            end
            ph_st = 0; ph_ones = 0; ph_n = 0; phy_oe = 1'b0; phy_out = 1'b1;
        end else begin
            ph_b = mdio_a;
            case (ph_st)
                0: begin
                    if (ph_b) ph_ones++;
                    else begin
                        if (ph_ones >= 32) ph_st = 1;
                        ph_ones = 0;
                    end
                end
                1: begin ph_st = ph_b ? 2 : 0; ph_n = 0; end
                2: begin
                    ph_hdr = {ph_hdr[10:0], ph_b};
                    ph_n++;
                    if (ph_n == 12) begin
                        ph_n = 0;
                        if (ph_hdr[11:10] == 2'b10)      ph_st = 3;
                        else if (ph_hdr[11:10] == 2'b01) ph_st = 5;
                        else                              ph_st = 0;
                    end
                end
                3: begin
                    if (ph_hdr[9:5] == PHY_AD) begin
                        phy_oe = 1'b1; phy_out = 1'b0;
                        ph_rdv = phy_regs[ph_hdr[4:0]];
                        ph_n = 0; ph_st = 4;
                    end else ph_st = 0;
                end
                4: begin
                    if (ph_n == 16) begin phy_oe = 1'b0; phy_out = 1'b1; ph_st = 0; end
                    else begin phy_out = ph_rdv[15 - ph_n]; ph_n++; end
                end
                5: begin
                    ph_wr = {ph_wr[16:0], ph_b};
                    ph_n++;
                    if (ph_n == 18) begin
                        if (ph_hdr[9:5] == PHY_AD && ph_wr[17:16] == 2'b10)
                            phy_regs[ph_hdr[4:0]] = ph_wr[15:0];
                        ph_st = 0;
                    end
                end
                default: ph_st = 0;
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame on instance A; checks latency and per-cycle mdc/oe/busy/ready shape
    task automatic run_a(input string tag, input logic wr, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd, input bit noise);
        int lat;
        int bad;
        logic exp_mdc, exp_oe;
        @(negedge clk);
        cv_a = 1'b1; cw_a = wr; cpa_a = pa; cra_a = ra; cwd_a = wd;
        check_val({tag, "_ready"}, 64'(ready_a), 64'd1);
        @(posedge clk);
        #1;
        cv_a = 1'b0; cw_a = ~wr; cpa_a = ~pa; cra_a = ~ra; cwd_a = ~wd;
        lat = -1;
        bad = 0;
        for (int k = 0; k < 2000 && lat < 0; k++) begin
            @(negedge clk);
            if (noise) begin
                cv_a  = (k >= 500) ? 1'b1 : 1'($urandom);
                cw_a  = 1'($urandom);
                cpa_a = 5'($urandom);
                cra_a = 5'($urandom);
                cwd_a = 16'($urandom);
            end
            if (done_a) lat = k + 1;
            exp_mdc = (k < 512) && ((k % 8) >= 4);
            exp_oe  = (k < 512) && (wr || k < 368);
            if (mdc_a !== exp_mdc || oe_a !== exp_oe || busy_a !== 1'b1 || ready_a !== 1'b0) bad++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'd513);
        check_val({tag, "_shape"}, 64'(bad), 64'd0);
        @(negedge clk);
        cv_a = 1'b0;
        check_val({tag, "_idle"}, 64'({busy_a, ready_a, done_a}), 64'(3'b010));
    endtask

    int lat_b, s0, dcnt;

    initial begin
        rst_a = 1'b0; cv_a = 1'b0; cw_a = 1'b0; cpa_a = '0; cra_a = '0; cwd_a = '0;
        rst_b = 1'b0; cv_b = 1'b0; cw_b = 1'b0; cpa_b = '0; cra_b = '0; cwd_b = '0;
        phy_clr = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("a_reset_ctl", 64'({mdc_a, out_a, oe_a, ready_a, busy_a, done_a, rde_a}), 64'(7'b0101000));
        check_val("a_reset_rd_data", 64'(rdd_a), 64'h0);
        check_val("b_reset_ctl", 64'({mdc_b, out_b, oe_b, ready_b, busy_b, done_b, rde_b}), 64'(7'b0101000));
        rst_a = 1'b1; rst_b = 1'b1;
        phy_clr = 1'b1;
        #1 phy_clr = 1'b0;

        // Preamble-suppressed back-to-back writes on instance B
        s0 = scnt_b;
        @(negedge clk);
        cv_b = 1'b1; cw_b = 1'b1; cpa_b = 5'h03; cra_b = 5'h00; cwd_b = 16'h1234;
        @(posedge clk);
        #1 cwd_b = 16'h5678;
        lat_b = -1;
        for (int k = 0; k < 400 && lat_b < 0; k++) begin
            @(negedge clk);
            if (done_b) lat_b = k + 1;
        end
        check_val("b_lat1", 64'(lat_b), 64'd129);
        check_val("b_stream1", 64'(stream_b), 64'({2'b01, 2'b01, 5'h03, 5'h00, 2'b10, 16'h1234}));
        check_val("b_bits1", 64'(scnt_b - s0), 64'd32);
        @(negedge clk);
        check_val("b_gap_idle", 64'({busy_b, ready_b}), 64'(2'b01));
        @(negedge clk);
        check_val("b_second_accept", 64'({busy_b, ready_b}), 64'(2'b10));
        cv_b = 1'b0;
        s0 = scnt_b;
        lat_b = -1;
        for (int k = 1; k < 400 && lat_b < 0; k++) begin
            @(negedge clk);
            if (done_b) lat_b = k + 1;
        end
        check_val("b_lat2", 64'(lat_b), 64'd129);
        check_val("b_stream2", 64'(stream_b), 64'({2'b01, 2'b01, 5'h03, 5'h00, 2'b10, 16'h5678}));

        // Read aborted by a 1-clk reset in the middle of DATA
        @(negedge clk);
        cv_a = 1'b1; cw_a = 1'b0; cpa_a = PHY_AD; cra_a = 5'h04;
        @(posedge clk);
        #1 cv_a = 1'b0;
        repeat (450) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check_val("a_abort_pins", 64'({mdc_a, oe_a, busy_a, done_a, ready_a, out_a}), 64'(6'b000011));
        check_val("a_abort_rd_data", 64'(rdd_a), 64'h0);
        dcnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (done_a || busy_a) dcnt++;
        end
        check_val("a_abort_quiet", 64'(dcnt), 64'd0);
        phy_clr = 1'b1;
        #1 phy_clr = 1'b0;

        s0 = scnt_a;
        run_a("a_wr", 1'b1, PHY_AD, 5'h04, 16'hA5C3, 1'b0);
        check_val("a_wr_stream", stream_a,
                  {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'hA5C3});
        check_val("a_wr_bits", 64'(scnt_a - s0), 64'd64);
        check_val("a_wr_phyreg", 64'(phy_regs[4]), 64'hA5C3);

        run_a("a_rd", 1'b0, PHY_AD, 5'h04, 16'h0000, 1'b0);
        check_val("a_rd_data", 64'(rdd_a), 64'hA5C3);
        check_val("a_rd_err", 64'(rde_a), 64'd0);

        run_a("a_absent", 1'b0, 5'h1F, 5'h04, 16'h0000, 1'b0);
        check_val("a_absent_data", 64'(rdd_a), 64'hFFFF);
        check_val("a_absent_err", 64'(rde_a), 64'd1);

        run_a("a_noise_wr", 1'b1, PHY_AD, 5'h07, 16'h3C5A, 1'b1);
        check_val("a_noise_phyreg", 64'(phy_regs[7]), 64'h3C5A);
        check_val("a_rd_data_held", 64'(rdd_a), 64'hFFFF);

        run_a("a_rd7", 1'b0, PHY_AD, 5'h07, 16'h0000, 1'b0);
        check_val("a_rd7_data", 64'(rdd_a), 64'h3C5A);
        check_val("a_rd7_err", 64'(rde_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
